// File: rtl/hsm_pkg.sv
// hsm_pkg: shared types and constants for the HSM key path.
//   hsm_arb_state_t : key arbiter FSM state encoding
//   HSM_KEY_W       : effective key width, shared with key_vault
//   sat_inc32()     : saturating 32-bit increment for event counters
package hsm_pkg;

    localparam int unsigned HSM_KEY_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        LEASE,
        SCRUB
    } hsm_arb_state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/hsm_rr_picker.sv
// hsm_rr_picker: combinational round-robin picker.
// Selects the first asserted request at an index >= ptr, wrapping modulo NUM_REQ.
// Ports:
//   req   in  NUM_REQ  request vector
//   ptr   in  IDX_W    round-robin start index
//   grant out NUM_REQ  one-hot winner (zero when nothing requests)
//   idx   out IDX_W    winner index (zero when nothing requests)
//   found out 1        at least one request asserted
module hsm_rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    int unsigned pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pos = (32'(ptr) + i) % NUM_REQ;
            if (!found && req[IDX_W'(pos)]) begin
                found = 1'b1;
                idx   = IDX_W'(pos);
            end
        end
        if (found) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/hsm_key_arbiter.sv
// hsm_key_arbiter: leases the key vault's effective key to one of NUM_REQ engines at a time.
// Round-robin arbitration, time-bounded leases, denial while the vault is locked, tampered
// or keyless, and a scrub cycle with the key bus at zero between leases.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid[NUM_REQ]    per-requester request, held until its req_done pulse
//   req_rel[NUM_REQ]      per-requester release, honoured only for the current owner
//   req_done[NUM_REQ]     one-hot decision pulse; req_ok qualifies it (1=grant, 0=deny)
//   vault_key/_key_vld    key_vault effective key and its valid flag
//   vault_locked/_tamper  key_vault lock and tamper status
//   key_out/key_out_vld   leased key (zero outside a lease) and lease-active flag
//   key_owner             index of current or last owner
//   grant_cnt/deny_cnt    saturating grant and deny counters
//   busy                  FSM not idle
// Build option HSM_ARB_AUDIT_EN adds timeout_cnt and revoke_cnt (saturating lease-exit
// counters for timeout and lock/tamper revocation).
module hsm_key_arbiter
    import hsm_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned KEY_W        = HSM_KEY_W,
    parameter int unsigned LEASE_CYCLES = 16,
    localparam int unsigned IDX_W       = $clog2(NUM_REQ),
    localparam int unsigned LC_W        = $clog2(LEASE_CYCLES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_rel,
    output logic [NUM_REQ-1:0] req_done,
    output logic               req_ok,
    input  logic [KEY_W-1:0]   vault_key,
    input  logic               vault_key_vld,
    input  logic               vault_locked,
    input  logic               vault_tamper,
    output logic [KEY_W-1:0]   key_out,
    output logic               key_out_vld,
    output logic [IDX_W-1:0]   key_owner,
    output logic [31:0]        grant_cnt,
    output logic [31:0]        deny_cnt,
    output logic               busy
`ifdef HSM_ARB_AUDIT_EN
    ,
    output logic [31:0]        timeout_cnt,
    output logic [31:0]        revoke_cnt
`endif
);

    hsm_arb_state_t     state_q, state_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [LC_W-1:0]    lease_q, lease_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               ok_q, ok_d;
    logic [31:0]        grant_cnt_q, grant_cnt_d;
    logic [31:0]        deny_cnt_q, deny_cnt_d;
`ifdef HSM_ARB_AUDIT_EN
    logic [31:0]        timeout_cnt_q, timeout_cnt_d;
    logic [31:0]        revoke_cnt_q, revoke_cnt_d;
`endif

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic [IDX_W-1:0]   rr_next;
    logic               blocked;
    logic               rel_hit;
    logic               revoke;

    hsm_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req   (req_valid),
        .ptr   (rr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign rr_next = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    assign blocked = vault_locked | vault_tamper | ~vault_key_vld;
    assign rel_hit = req_rel[owner_q];
    assign revoke  = vault_locked | vault_tamper;

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        owner_d       = owner_q;
        lease_d       = lease_q;
        key_d         = key_q;
        done_d        = '0;
        ok_d          = 1'b0;
        grant_cnt_d   = grant_cnt_q;
        deny_cnt_d    = deny_cnt_q;
`ifdef HSM_ARB_AUDIT_EN
        timeout_cnt_d = timeout_cnt_q;
        revoke_cnt_d  = revoke_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                state_d = IDLE;
                // A requester may have dropped out since IDLE; with nobody left, no decision.
                if (pick_found) begin
                    done_d = pick_grant;
                    rr_d   = rr_next;
                    if (blocked) begin
                        deny_cnt_d = sat_inc32(deny_cnt_q);
                    end else begin
                        ok_d        = 1'b1;
                        grant_cnt_d = sat_inc32(grant_cnt_q);
                        owner_d     = pick_idx;
                        key_d       = vault_key;
                        lease_d     = LC_W'(LEASE_CYCLES - 1);
                        state_d     = LEASE;
                    end
                end
            end
            LEASE: begin
                lease_d = lease_q - 1'b1;
                // Release wins over everything so a release coinciding with timeout
                // is recorded as a release.
                if (rel_hit) begin
                    state_d = SCRUB;
                end else if (revoke) begin
                    state_d = SCRUB;
`ifdef HSM_ARB_AUDIT_EN
                    revoke_cnt_d = sat_inc32(revoke_cnt_q);
`endif
                end else if (lease_q == '0) begin
                    state_d = SCRUB;
`ifdef HSM_ARB_AUDIT_EN
                    timeout_cnt_d = sat_inc32(timeout_cnt_q);
`endif
                end
                if (state_d == SCRUB) begin
                    key_d = '0;
                end
            end
            SCRUB: begin
                key_d   = '0;
                state_d = IDLE;
            end
            default: begin
                key_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rr_q          <= '0;
            owner_q       <= '0;
            lease_q       <= '0;
            key_q         <= '0;
            done_q        <= '0;
            ok_q          <= 1'b0;
            grant_cnt_q   <= '0;
            deny_cnt_q    <= '0;
`ifdef HSM_ARB_AUDIT_EN
            timeout_cnt_q <= '0;
            revoke_cnt_q  <= '0;
`endif
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            owner_q       <= owner_d;
            lease_q       <= lease_d;
            key_q         <= key_d;
            done_q        <= done_d;
            ok_q          <= ok_d;
            grant_cnt_q   <= grant_cnt_d;
            deny_cnt_q    <= deny_cnt_d;
`ifdef HSM_ARB_AUDIT_EN
            timeout_cnt_q <= timeout_cnt_d;
            revoke_cnt_q  <= revoke_cnt_d;
`endif
        end
    end

    assign req_done    = done_q;
    assign req_ok      = ok_q;
    assign key_out     = key_q;
    assign key_out_vld = (state_q == LEASE);
    assign key_owner   = owner_q;
    assign grant_cnt   = grant_cnt_q;
    assign deny_cnt    = deny_cnt_q;
    assign busy        = (state_q != IDLE);
`ifdef HSM_ARB_AUDIT_EN
    assign timeout_cnt = timeout_cnt_q;
    assign revoke_cnt  = revoke_cnt_q;
`endif

endmodule

// File: tb/tb_hsm_key_arbiter.sv
// tb_hsm_key_arbiter: self-checking bench for hsm_key_arbiter (NUM_REQ=4, KEY_W=128,
// LEASE_CYCLES=16). Expected decisions are queued when requests are raised and compared
// by a monitor when req_done pulses. Audit counters are checked when HSM_ARB_AUDIT_EN
// is defined.
module tb_hsm_key_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned KEY_W   = 128;
    localparam int unsigned LEASE   = 16;

    localparam logic [KEY_W-1:0] K1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [KEY_W-1:0] K2 = 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0;
    localparam logic [KEY_W-1:0] K3 = 128'h5A5A_A5A5_0F0F_F0F0_1111_2222_3333_4444;
    localparam logic [KEY_W-1:0] KA = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;

    logic               clk;
    logic               rst_n;
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_rel;
    logic [NUM_REQ-1:0] req_done;
    logic               req_ok;
    logic [KEY_W-1:0]   vault_key;
    logic               vault_key_vld;
    logic               vault_locked;
    logic               vault_tamper;
    logic [KEY_W-1:0]   key_out;
    logic               key_out_vld;
    logic [1:0]         key_owner;
    logic [31:0]        grant_cnt;
    logic [31:0]        deny_cnt;
    logic               busy;
`ifdef HSM_ARB_AUDIT_EN
    logic [31:0]        timeout_cnt;
    logic [31:0]        revoke_cnt;
`endif

    typedef struct packed {
        logic [NUM_REQ-1:0] done;
        logic               ok;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    hsm_key_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .KEY_W        (KEY_W),
        .LEASE_CYCLES (LEASE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_rel       (req_rel),
        .req_done      (req_done),
        .req_ok        (req_ok),
        .vault_key     (vault_key),
        .vault_key_vld (vault_key_vld),
        .vault_locked  (vault_locked),
        .vault_tamper  (vault_tamper),
        .key_out       (key_out),
        .key_out_vld   (key_out_vld),
        .key_owner     (key_owner),
        .grant_cnt     (grant_cnt),
        .deny_cnt      (deny_cnt),
        .busy          (busy)
`ifdef HSM_ARB_AUDIT_EN
        ,
        .timeout_cnt   (timeout_cnt),
        .revoke_cnt    (revoke_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: every decision pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && req_done !== '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got done=%b ok=%b, required no decision",
                         req_done, req_ok);
            end else begin
                mon_e = exp_q.pop_front();
                if (req_done !== mon_e.done || req_ok !== mon_e.ok) begin
                    errors++;
                    $display("FAIL sb_decision: got done=%b ok=%b, required done=%b ok=%b",
                             req_done, req_ok, mon_e.done, mon_e.ok);
                end
            end
        end
    end

    task automatic wait_done(output logic [NUM_REQ-1:0] seen, output bit to);
        to   = 1'b1;
        seen = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (req_done !== '0) begin
                seen = req_done;
                to   = 1'b0;
                break;
            end
        end
    endtask

    task automatic hard_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        req_valid     = '0;
        req_rel       = '0;
        vault_key     = '0;
        vault_key_vld = 1'b0;
        vault_locked  = 1'b0;
        vault_tamper  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (key_out !== '0 || key_out_vld !== 1'b0 || req_done !== '0 || req_ok !== 1'b0 ||
            key_owner !== '0 || grant_cnt !== '0 || deny_cnt !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got key=%h vld=%b done=%b ok=%b own=%0d g=%0d d=%0d busy=%b, required all 0",
                     key_out, key_out_vld, req_done, req_ok, key_owner, grant_cnt, deny_cnt, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_grant();
        logic [NUM_REQ-1:0] seen;
        bit                 to;
        int                 n;
        vault_key     = K1;
        vault_key_vld = 1'b1;
        exp_q.push_back('{done: 4'b0001, ok: 1'b1});
        req_valid = 4'b0001;
        wait_done(seen, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL single_timeout: got no req_done, required done=0001");
        end
        req_valid = '0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (key_out_vld !== 1'b1) break;
            n++;
            checks++;
            if (key_out !== K1) begin
                errors++;
                $display("FAIL single_key: got %h, required %h", key_out, K1);
            end
            // A non-owner release in cycle 1 must be ignored; owner releases in cycle 3.
            if (n == 1) req_rel = 4'b0010;
            else if (n == 2) req_rel = '0;
            else if (n == 3) req_rel = 4'b0001;
            @(negedge clk);
        end
        req_rel = '0;
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL single_lease_len: got %0d cycles, required 3", n);
        end
        checks++;
        if (key_out !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_scrub: got key=%h busy=%b, required key=0 busy=1", key_out, busy);
        end
        checks++;
        if (grant_cnt !== 32'd1 || key_owner !== 2'd0) begin
            errors++;
            $display("FAIL single_counts: got grant_cnt=%0d owner=%0d, required 1 and 0",
                     grant_cnt, key_owner);
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [NUM_REQ-1:0] seen;
        bit                 to;
        int                 order [5] = '{0, 1, 2, 3, 0};
        hard_reset();
        vault_key = K2;
        for (int g = 0; g < 5; g++) begin
            exp_q.push_back('{done: 4'(1 << order[g]), ok: 1'b1});
        end
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_done(seen, to);
            checks++;
            if (to) begin
                errors++;
                $display("FAIL rr_timeout: got no req_done for grant %0d", g);
            end
            checks++;
            if (key_owner !== 2'(order[g])) begin
                errors++;
                $display("FAIL rr_owner: got owner=%0d, required %0d", key_owner, order[g]);
            end
            if (g == 4) req_valid = '0;
            req_rel = seen;
            @(negedge clk);
            req_rel = '0;
        end
        checks++;
        if (grant_cnt !== 32'd5) begin
            errors++;
            $display("FAIL rr_grant_cnt: got %0d, required 5", grant_cnt);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_locked_deny();
        logic [NUM_REQ-1:0] seen;
        bit                 to;
        vault_locked = 1'b1;
        exp_q.push_back('{done: 4'b0100, ok: 1'b0});
        req_valid = 4'b0100;
        wait_done(seen, to);
        req_valid = '0;
        checks++;
        if (to) begin
            errors++;
            $display("FAIL lock_timeout: got no req_done, required done=0100");
        end
        checks++;
        if (deny_cnt !== 32'd1) begin
            errors++;
            $display("FAIL lock_deny_cnt: got %0d, required 1", deny_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (key_out_vld !== 1'b0 || key_out !== '0) begin
                errors++;
                $display("FAIL lock_no_lease: got vld=%b key=%h, required vld=0 key=0",
                         key_out_vld, key_out);
            end
            @(negedge clk);
        end
        vault_locked = 1'b0;
    endtask

    task automatic test_timeout();
        logic [NUM_REQ-1:0] seen;
        bit                 to;
        int                 n;
        vault_key = K2;
        exp_q.push_back('{done: 4'b0100, ok: 1'b1});
        req_valid = 4'b0100;
        wait_done(seen, to);
        req_valid = '0;
        checks++;
        if (to) begin
            errors++;
            $display("FAIL tmo_timeout: got no req_done, required done=0100");
        end
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (key_out_vld !== 1'b1) break;
            n++;
            checks++;
            if (key_out !== K2) begin
                errors++;
                $display("FAIL tmo_key_hold: got %h, required %h", key_out, K2);
            end
            // The vault key changing mid-lease must not be re-sampled.
            if (n == 4) vault_key = KA;
            @(negedge clk);
        end
        checks++;
        if (n != int'(LEASE)) begin
            errors++;
            $display("FAIL tmo_lease_len: got %0d cycles, required %0d", n, LEASE);
        end
        checks++;
        if (key_out !== '0 || grant_cnt !== 32'd6) begin
            errors++;
            $display("FAIL tmo_after: got key=%h grant_cnt=%0d, required key=0 grant_cnt=6",
                     key_out, grant_cnt);
        end
`ifdef HSM_ARB_AUDIT_EN
        checks++;
        if (timeout_cnt !== 32'd1) begin
            errors++;
            $display("FAIL tmo_audit: got timeout_cnt=%0d, required 1", timeout_cnt);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_tamper();
        logic [NUM_REQ-1:0] seen;
        bit                 to;
        int                 n;
        vault_key = K3;
        exp_q.push_back('{done: 4'b0001, ok: 1'b1});
        req_valid = 4'b0001;
        wait_done(seen, to);
        req_valid = '0;
        checks++;
        if (to) begin
            errors++;
            $display("FAIL tamp_timeout: got no req_done, required done=0001");
        end
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (key_out_vld !== 1'b1) break;
            n++;
            checks++;
            if (key_out !== K3) begin
                errors++;
                $display("FAIL tamp_key: got %h, required %h", key_out, K3);
            end
            if (n == 5) vault_tamper = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (n != 5 || key_out !== '0) begin
            errors++;
            $display("FAIL tamp_revoke: got %0d cycles key=%h, required 5 cycles key=0",
                     n, key_out);
        end
        exp_q.push_back('{done: 4'b0010, ok: 1'b0});
        req_valid = 4'b0010;
        wait_done(seen, to);
        req_valid = '0;
        checks++;
        if (to || deny_cnt !== 32'd2 || grant_cnt !== 32'd7) begin
            errors++;
            $display("FAIL tamp_deny: got to=%b deny_cnt=%0d grant_cnt=%0d, required 0, 2, 7",
                     to, deny_cnt, grant_cnt);
        end
`ifdef HSM_ARB_AUDIT_EN
        checks++;
        if (revoke_cnt !== 32'd1) begin
            errors++;
            $display("FAIL tamp_audit: got revoke_cnt=%0d, required 1", revoke_cnt);
        end
`endif
        vault_tamper = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_lease();
        logic [NUM_REQ-1:0] seen;
        bit                 to;
        vault_key = K1;
        exp_q.push_back('{done: 4'b1000, ok: 1'b1});
        req_valid = 4'b1000;
        wait_done(seen, to);
        req_valid = '0;
        checks++;
        if (to || key_out_vld !== 1'b1) begin
            errors++;
            $display("FAIL rst_lease_start: got to=%b vld=%b, required 0 and 1", to, key_out_vld);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (key_out !== '0 || key_out_vld !== 1'b0 || grant_cnt !== '0 || deny_cnt !== '0 ||
            busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: got key=%h vld=%b g=%0d d=%0d busy=%b, required all 0",
                     key_out, key_out_vld, grant_cnt, deny_cnt, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.push_back('{done: 4'b0001, ok: 1'b1});
        req_valid = 4'b1111;
        wait_done(seen, to);
        req_valid = '0;
        checks++;
        if (to || key_owner !== 2'd0) begin
            errors++;
            $display("FAIL rst_first_grant: got to=%b owner=%0d, required 0 and 0", to, key_owner);
        end
        req_rel = 4'b0001;
        @(negedge clk);
        req_rel = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending decisions, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_round_robin();
        test_locked_deny();
        test_timeout();
        test_tamper();
        test_reset_mid_lease();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
